reg_manager: RTL and testbench

- Register manager on the issue side of the CPU.
- Accepts decoded instructions and holds the 32-entry integer register file.
- Tracks pending destinations with a scoreboard, then drives operands and control to the execution units (ALU et al.) over the unit/sub_unit/sel/rs1/rs2/rd/immediate/imm interface, using their ok handshake.
- Collects unit writebacks into the register file.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/reg_manager_if.sv | 40 ++++
 rtl/reg_manager_regfile.sv | 37 +++
 rtl/reg_manager.sv | 115 +++++++++++
 tb/tb_reg_manager.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared issue-side CPU types: datapath width, unit codes, issue bundle and manager FSM states.
package cpu_pkg;
  localparam int xlen  = 32;
  localparam int nregs = 32;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'h0,
    UNIT_MUL = 2'h1,
    UNIT_LSU = 2'h2,
    UNIT_BRU = 2'h3
  } unit_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]      unit;
    logic [2:0]      sub_unit;
    logic [5:0]      sel;
    logic [xlen-1:0] rs1;
    logic [xlen-1:0] rs2;
    logic [4:0]      rd;
    logic [xlen-1:0] immediate;
    logic            imm;
  } issue_t;

  // Decoded instruction as held while waiting on the scoreboard (register indices, not values).
  typedef struct packed {
    logic [1:0]      unit;
    logic [2:0]      sub_unit;
    logic [5:0]      sel;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [xlen-1:0] immediate;
    logic            imm;
  } dec_t;

  function automatic logic has_hazard(logic [nregs-1:0] busy, dec_t d);
    return busy[d.rs1] | (~d.imm & busy[d.rs2]) | busy[d.rd];
  endfunction
endpackage

// File: rtl/reg_manager_if.sv
// Decode, issue-bundle and writeback signals between the register manager and its neighbours.
interface reg_manager_if;
  import cpu_pkg::*;

  logic            dec_valid_i;
  logic            dec_ready_o;
  logic [1:0]      dec_unit_i;
  logic [2:0]      dec_sub_unit_i;
  logic [5:0]      dec_sel_i;
  logic [4:0]      dec_rs1_i;
  logic [4:0]      dec_rs2_i;
  logic [4:0]      dec_rd_i;
  logic [xlen-1:0] dec_immediate_i;
  logic            dec_imm_i;
  logic            issue_valid_o;
  logic [1:0]      unit;
  logic [2:0]      sub_unit;
  logic [5:0]      sel;
  logic [xlen-1:0] rs1;
  logic [xlen-1:0] rs2;
  logic [4:0]      rd;
  logic [xlen-1:0] immediate;
  logic            imm;
  logic            ok_i;
  logic            wb_valid_i;
  logic [4:0]      wb_rd_i;
  logic [xlen-1:0] wb_data_i;

  modport slave (
    input  dec_valid_i, dec_unit_i, dec_sub_unit_i, dec_sel_i, dec_rs1_i, dec_rs2_i,
           dec_rd_i, dec_immediate_i, dec_imm_i, ok_i, wb_valid_i, wb_rd_i, wb_data_i,
    output dec_ready_o, issue_valid_o, unit, sub_unit, sel, rs1, rs2, rd, immediate, imm
  );

  modport master (
    output dec_valid_i, dec_unit_i, dec_sub_unit_i, dec_sel_i, dec_rs1_i, dec_rs2_i,
           dec_rd_i, dec_immediate_i, dec_imm_i, ok_i, wb_valid_i, wb_rd_i, wb_data_i,
    input  dec_ready_o, issue_valid_o, unit, sub_unit, sel, rs1, rs2, rd, immediate, imm
  );
endinterface

// File: rtl/reg_manager_regfile.sv
// 32-entry integer register file: two async read ports with write-through, one write port, x0 = 0.
module reg_manager_regfile
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [xlen-1:0] rdata1,
  output logic [xlen-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [xlen-1:0] wd
);
  logic [xlen-1:0] mem_q [nregs];
  logic [xlen-1:0] mem_d [nregs];
  logic            wr_en;

  assign wr_en = we & (wa != 5'd0);

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wa] = wd;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < nregs; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Same-cycle writeback is forwarded so a release read never sees stale data.
  assign rdata1 = (ra1 == 5'd0) ? '0 : ((wr_en && wa == ra1) ? wd : mem_q[ra1]);
  assign rdata2 = (ra2 == 5'd0) ? '0 : ((wr_en && wa == ra2) ? wd : mem_q[ra2]);
endmodule

// File: rtl/reg_manager.sv
// Issue-side register manager: holds a decoded instruction, stalls on scoreboard hazards,
// drives the operand bundle to the execution units and retires unit writebacks.
module reg_manager
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  reg_manager_if.slave bus
);
  // state  | meaning
  // IDLE   | no instruction held, ready for decode
  // STALL  | instruction held, waiting for its sources / destination to clear
  // ISSUE  | bundle presented, waiting for ok_i

  state_t             state_q, state_d;
  dec_t               hold_q, hold_d;
  issue_t             bundle_q, bundle_d;
  logic [nregs-1:0]   busy_q, busy_d;
  dec_t               dec_in;
  logic [4:0]         ra1, ra2;
  logic [xlen-1:0]    rdata1, rdata2;
  logic               fire, capture, dec_ready;

  assign dec_in = '{unit: bus.dec_unit_i, sub_unit: bus.dec_sub_unit_i, sel: bus.dec_sel_i,
                    rs1: bus.dec_rs1_i, rs2: bus.dec_rs2_i, rd: bus.dec_rd_i,
                    immediate: bus.dec_immediate_i, imm: bus.dec_imm_i};

  assign fire    = (state_q == ST_ISSUE) & bus.ok_i;
  assign capture = bus.dec_valid_i & dec_ready;
  assign ra1     = (state_q == ST_STALL) ? hold_q.rs1 : bus.dec_rs1_i;
  assign ra2     = (state_q == ST_STALL) ? hold_q.rs2 : bus.dec_rs2_i;

  reg_manager_regfile u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .ra1    (ra1),
    .ra2    (ra2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (bus.wb_valid_i),
    .wa     (bus.wb_rd_i),
    .wd     (bus.wb_data_i)
  );

  function automatic issue_t mk_issue(dec_t d, logic [xlen-1:0] a, logic [xlen-1:0] b);
    issue_t r;
    r = '{unit: d.unit, sub_unit: d.sub_unit, sel: d.sel, rs1: a, rs2: b, rd: d.rd,
          immediate: d.immediate, imm: d.imm};
    return r;
  endfunction

  // Set is applied after clear so a new producer on the same rd stays outstanding.
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_valid_i && bus.wb_rd_i != 5'd0) busy_d[bus.wb_rd_i] = 1'b0;
    if (fire && bundle_q.rd != 5'd0) busy_d[bundle_q.rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      bundle_q <= '0;
      busy_q   <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      bundle_q <= bundle_d;
      busy_q   <= busy_d;
    end
  end

  // Hazards are judged against the post-update scoreboard, matching the forwarded operands.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    bundle_d = bundle_q;
    if (capture) begin
      hold_d = dec_in;
      if (has_hazard(busy_d, dec_in)) begin
        state_d = ST_STALL;
      end else begin
        bundle_d = mk_issue(dec_in, rdata1, rdata2);
        state_d  = ST_ISSUE;
      end
    end else if (state_q == ST_STALL) begin
      if (!has_hazard(busy_d, hold_q)) begin
        bundle_d = mk_issue(hold_q, rdata1, rdata2);
        state_d  = ST_ISSUE;
      end
    end else if (fire) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    dec_ready = 1'b0;
    case (state_q)
      ST_IDLE:  dec_ready = 1'b1;
      ST_ISSUE: dec_ready = bus.ok_i;
      default:  dec_ready = 1'b0;
    endcase
  end

  assign bus.dec_ready_o   = dec_ready;
  assign bus.issue_valid_o = (state_q == ST_ISSUE);
  assign bus.unit          = bundle_q.unit;
  assign bus.sub_unit      = bundle_q.sub_unit;
  assign bus.sel           = bundle_q.sel;
  assign bus.rs1           = bundle_q.rs1;
  assign bus.rs2           = bundle_q.rs2;
  assign bus.rd            = bundle_q.rd;
  assign bus.immediate     = bundle_q.immediate;
  assign bus.imm           = bundle_q.imm;
endmodule

// File: tb/tb_reg_manager.sv
// Bench for reg_manager: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against an instruction-level reference model.
module tb_reg_manager;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_manager_if bus();
  reg_manager dut (.clk(clk), .rst_n(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (instruction level) ----------------
  typedef struct {
    bit [1:0]  unit;
    bit [2:0]  sub;
    bit [5:0]  sel;
    bit [4:0]  s1, s2, d;
    bit [31:0] immv;
    bit        imm;
  } instr_t;

  bit [31:0] m_reg [32];
  bit        m_busy [32];
  bit        nb [32];
  bit        m_out_v;
  instr_t    m_out_i;
  bit [31:0] m_out_a, m_out_b;
  bit        m_wait;
  instr_t    m_wait_i;
  instr_t    cur;
  bit        acc, fire;

  function automatic bit m_blocked(instr_t x, bit b[32]);
    return b[x.s1] || (!x.imm && b[x.s2]) || b[x.d];
  endfunction

  function automatic bit [31:0] m_read(bit [4:0] idx);
    if (idx == 0) return 32'h0;
    if (bus.wb_valid_i && bus.wb_rd_i == idx) return bus.wb_data_i;
    return m_reg[idx];
  endfunction

  function automatic bit m_ready();
    if (m_out_v) return bus.ok_i;
    return !m_wait;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_busy[i] = 0; end
      m_out_v = 0;
      m_wait  = 0;
    end else begin
      acc  = bus.dec_valid_i && m_ready();
      fire = m_out_v && bus.ok_i;
      nb   = m_busy;
      if (bus.wb_valid_i && bus.wb_rd_i != 0) nb[bus.wb_rd_i] = 0;
      if (fire && m_out_i.d != 0) nb[m_out_i.d] = 1;
      if (fire) m_out_v = 0;
      if (acc) begin
        cur = '{unit: bus.dec_unit_i, sub: bus.dec_sub_unit_i, sel: bus.dec_sel_i,
                s1: bus.dec_rs1_i, s2: bus.dec_rs2_i, d: bus.dec_rd_i,
                immv: bus.dec_immediate_i, imm: bus.dec_imm_i};
        if (m_blocked(cur, nb)) begin
          m_wait = 1; m_wait_i = cur;
        end else begin
          m_out_i = cur; m_out_a = m_read(cur.s1); m_out_b = m_read(cur.s2); m_out_v = 1;
        end
      end else if (m_wait && !m_blocked(m_wait_i, nb)) begin
        m_out_i = m_wait_i; m_out_a = m_read(m_wait_i.s1); m_out_b = m_read(m_wait_i.s2);
        m_out_v = 1; m_wait = 0;
      end
      if (bus.wb_valid_i && bus.wb_rd_i != 0) m_reg[bus.wb_rd_i] = bus.wb_data_i;
      m_busy = nb;
    end
  end

  always @(negedge clk) begin
    chk("dec_ready", bus.dec_ready_o, m_ready());
    chk("issue_valid", bus.issue_valid_o, m_out_v);
    if (m_out_v) begin
      chk("unit", bus.unit, m_out_i.unit);
      chk("sub_unit", bus.sub_unit, m_out_i.sub);
      chk("sel", bus.sel, m_out_i.sel);
      chk("rs1", bus.rs1, m_out_a);
      chk("rs2", bus.rs2, m_out_b);
      chk("rd", bus.rd, m_out_i.d);
      chk("immediate", bus.immediate, m_out_i.immv);
      chk("imm", bus.imm, m_out_i.imm);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic nxt();
    @(posedge clk); #1;
    bus.dec_valid_i = 0; bus.ok_i = 0; bus.wb_valid_i = 0;
  endtask

  task automatic dec(input bit [4:0] s1, input bit [4:0] s2, input bit [4:0] d,
                     input bit imm, input bit [31:0] iv);
    bus.dec_valid_i = 1; bus.dec_unit_i = 2'h0; bus.dec_sub_unit_i = 3'd1; bus.dec_sel_i = 6'd5;
    bus.dec_rs1_i = s1; bus.dec_rs2_i = s2; bus.dec_rd_i = d; bus.dec_imm_i = imm;
    bus.dec_immediate_i = iv;
  endtask

  task automatic wb(input bit [4:0] r, input bit [31:0] v);
    bus.wb_valid_i = 1; bus.wb_rd_i = r; bus.wb_data_i = v;
  endtask

  initial begin
    bus.dec_valid_i = 0; bus.dec_unit_i = 0; bus.dec_sub_unit_i = 0; bus.dec_sel_i = 0;
    bus.dec_rs1_i = 0; bus.dec_rs2_i = 0; bus.dec_rd_i = 0; bus.dec_immediate_i = 0;
    bus.dec_imm_i = 0; bus.ok_i = 0; bus.wb_valid_i = 0; bus.wb_rd_i = 0; bus.wb_data_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", bus.dec_ready_o, 1);
    chk("reset_issue_valid", bus.issue_valid_o, 0);
    nxt(); rst = 0;

    // every x1..x31 reads back zero, streamed back to back
    for (int i = 1; i < 32; i++) begin
      nxt(); dec(i[4:0], i[4:0], 0, 0, 0); bus.ok_i = (i > 1);
      @(negedge clk);
      if (i > 1) begin
        chk("reset_read_rs1", bus.rs1, 0);
        chk("reset_read_rs2", bus.rs2, 0);
      end
    end
    nxt(); bus.ok_i = 1;
    nxt();

    // plain issue
    wb(5, 32'h1234);
    nxt(); dec(5, 0, 6, 1, 32'h10);
    @(negedge clk); chk("plain_ready", bus.dec_ready_o, 1);
    nxt();
    @(negedge clk);
    chk("plain_valid", bus.issue_valid_o, 1);
    chk("plain_rs1", bus.rs1, 32'h1234);
    chk("plain_immediate", bus.immediate, 32'h10);
    chk("plain_rd", bus.rd, 6);
    nxt(); bus.ok_i = 1;
    nxt();

    // RAW stall on x6
    dec(6, 0, 8, 1, 0);
    nxt(); @(negedge clk);
    chk("raw_ready", bus.dec_ready_o, 0);
    chk("raw_valid", bus.issue_valid_o, 0);
    nxt(); wb(6, 32'hABCD); @(negedge clk);
    chk("raw_valid_wb", bus.issue_valid_o, 0);
    nxt(); bus.ok_i = 1; @(negedge clk);
    chk("raw_release", bus.issue_valid_o, 1);
    chk("raw_rs1", bus.rs1, 32'hABCD);
    nxt(); wb(8, 32'h88);

    // forwarding on release
    nxt(); dec(0, 0, 7, 1, 0);
    nxt(); bus.ok_i = 1;
    nxt(); dec(0, 7, 10, 0, 0);
    nxt(); wb(7, 32'h55); @(negedge clk);
    chk("fwd_stall", bus.issue_valid_o, 0);
    nxt(); bus.ok_i = 1; @(negedge clk);
    chk("fwd_valid", bus.issue_valid_o, 1);
    chk("fwd_rs2", bus.rs2, 32'h55);
    nxt(); wb(10, 32'h1010);

    // ok_i backpressure then back-to-back
    nxt(); dec(5, 0, 11, 1, 32'h20);
    for (int k = 0; k < 3; k++) begin
      nxt(); @(negedge clk);
      chk("bp_valid", bus.issue_valid_o, 1);
      chk("bp_rd", bus.rd, 11);
      chk("bp_rs1", bus.rs1, 32'h1234);
      chk("bp_ready", bus.dec_ready_o, 0);
    end
    nxt(); bus.ok_i = 1; dec(5, 0, 12, 1, 32'h30); @(negedge clk);
    chk("b2b_ready", bus.dec_ready_o, 1);
    nxt(); bus.ok_i = 1; @(negedge clk);
    chk("b2b_valid", bus.issue_valid_o, 1);
    chk("b2b_rd", bus.rd, 12);
    nxt(); wb(11, 32'h11);
    nxt(); wb(12, 32'h12);

    // rd=0 issue does not mark anything busy
    nxt(); dec(0, 0, 0, 1, 0);
    nxt(); bus.ok_i = 1; dec(0, 0, 13, 0, 0);
    nxt(); @(negedge clk);
    chk("rd0_no_busy_valid", bus.issue_valid_o, 1);
    chk("rd0_no_busy_rd", bus.rd, 13);
    bus.ok_i = 1;
    nxt(); wb(13, 32'h13);

    // writeback to x0 ignored, including the forwarding path
    nxt(); wb(0, 32'hFFFF_FFFF); dec(0, 0, 0, 0, 0);
    nxt(); @(negedge clk);
    chk("x0_rs1", bus.rs1, 0);
    chk("x0_rs2", bus.rs2, 0);
    bus.ok_i = 1;

    // same-cycle set/clear on x9: set wins
    nxt(); dec(0, 0, 9, 1, 0);
    nxt(); bus.ok_i = 1; wb(9, 32'h99);
    nxt(); dec(9, 0, 14, 1, 0);
    nxt(); @(negedge clk);
    chk("setclr_stall", bus.issue_valid_o, 0);
    chk("setclr_ready", bus.dec_ready_o, 0);
    nxt(); wb(9, 32'h77);
    nxt(); bus.ok_i = 1; @(negedge clk);
    chk("setclr_release", bus.issue_valid_o, 1);
    chk("setclr_rs1", bus.rs1, 32'h77);
    nxt(); wb(14, 32'h14);

    for (int r = 1; r < 32; r++) begin
      nxt(); wb(r[4:0], $urandom);
    end

    // randomized traffic, with one asynchronous reset in the middle
    for (int c = 0; c < 3000; c++) begin
      nxt();
      if (c == 1500) rst = 1;
      if (c == 1503) rst = 0;
      bus.dec_valid_i     = $urandom_range(0, 1);
      bus.dec_unit_i      = $urandom_range(0, 3);
      bus.dec_sub_unit_i  = $urandom_range(0, 7);
      bus.dec_sel_i       = $urandom_range(0, 63);
      bus.dec_rs1_i       = $urandom_range(0, 7);
      bus.dec_rs2_i       = $urandom_range(0, 7);
      bus.dec_rd_i        = $urandom_range(0, 7);
      bus.dec_imm_i       = $urandom_range(0, 1);
      bus.dec_immediate_i = $urandom;
      bus.ok_i            = ($urandom_range(0, 3) != 0);
      bus.wb_valid_i      = ($urandom_range(0, 2) == 0);
      bus.wb_rd_i         = $urandom_range(0, 7);
      bus.wb_data_i       = $urandom;
    end
    nxt();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
